// File: rtl/tx_dc_cmp_pkg.sv
// Shared types and constants for the TX DC compensation path.
// Saturation bounds are derived from the sample width.
package tx_dc_cmp_pkg;

    localparam int DW = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_st_e;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(DW);
    localparam longint SAT_MIN = sat_min(DW);

endpackage

// File: rtl/tx_dc_cmp_if.sv
// IQ stream, DC control and status bundle for tx_dc_cmp.
// master drives samples and control; slave is the compensator.
interface tx_dc_cmp_if #(
    parameter int DATA_WIDTH = 16
);

    logic signed [DATA_WIDTH-1:0] i_in;
    logic signed [DATA_WIDTH-1:0] q_in;
    logic                         iq_in_valid;
    logic                         dc_en;
    logic signed [DATA_WIDTH-1:0] dc_i_target;
    logic signed [DATA_WIDTH-1:0] dc_q_target;
    logic        [DATA_WIDTH-1:0] ramp_step;
    logic signed [DATA_WIDTH-1:0] i_out;
    logic signed [DATA_WIDTH-1:0] q_out;
    logic                         iq_out_valid;
    logic                         ramp_busy;

    modport master (
        output i_in, q_in, iq_in_valid,
        output dc_en, dc_i_target, dc_q_target, ramp_step,
        input  i_out, q_out, iq_out_valid, ramp_busy
    );

    modport slave (
        input  i_in, q_in, iq_in_valid,
        input  dc_en, dc_i_target, dc_q_target, ramp_step,
        output i_out, q_out, iq_out_valid, ramp_busy
    );

endinterface

// File: rtl/tx_dc_cmp_dc_ramp_ch.sv
// One channel's applied DC offset, stepped toward its target
// once per valid sample without overshoot.
module tx_dc_cmp_dc_ramp_ch
    import tx_dc_cmp_pkg::*;
#(
    parameter int DATA_WIDTH = DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_target,
    input  logic [DATA_WIDTH-1:0] i_step,
    output logic [DATA_WIDTH-1:0] o_applied,
    output logic                  o_ramp
);

    logic [DATA_WIDTH-1:0] r_applied;
    logic [DATA_WIDTH-1:0] w_tgt;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_mag;
    logic [DATA_WIDTH:0]   w_stepped;
    logic [DATA_WIDTH-1:0] w_next;
    ramp_st_e              w_state;

    assign w_tgt   = i_en ? i_target : '0;
    assign w_state = (w_tgt != r_applied) ? RAMP : IDLE;

    // Difference needs one extra bit: target and applied span the full range
    assign w_diff = {w_tgt[DATA_WIDTH-1], w_tgt}
                  - {r_applied[DATA_WIDTH-1], r_applied};
    assign w_mag  = w_diff[DATA_WIDTH] ? (~w_diff + 1'b1) : w_diff;

    assign w_stepped = w_diff[DATA_WIDTH]
        ? ({r_applied[DATA_WIDTH-1], r_applied} - {1'b0, i_step})
        : ({r_applied[DATA_WIDTH-1], r_applied} + {1'b0, i_step});

    always_comb begin
        w_next = w_stepped[DATA_WIDTH-1:0];
        if ((i_step == '0) || (w_mag <= {1'b0, i_step})) begin
            w_next = w_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_applied <= '0;
        end else if (i_valid && (w_state == RAMP)) begin
            r_applied <= w_next;
        end
    end

    assign o_applied = r_applied;
    assign o_ramp    = (w_state == RAMP);

endmodule

// File: rtl/tx_dc_cmp.sv
// TX DC compensation: adds a ramped per-channel offset to the IQ
// stream, with a two-stage add/saturate pipeline.
module tx_dc_cmp
    import tx_dc_cmp_pkg::*;
#(
    parameter int DATA_WIDTH = DW
) (
    input  logic    clk,
    input  logic    rst,
    tx_dc_cmp_if.slave s_bus
);

    localparam logic signed [DATA_WIDTH:0] L_MAX =
        (DATA_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH:0] L_MIN =
        (DATA_WIDTH+1)'(sat_min(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] w_i_app;
    logic [DATA_WIDTH-1:0] w_q_app;
    logic                  w_i_ramp;
    logic                  w_q_ramp;

    logic [DATA_WIDTH:0]   r_i_sum;
    logic [DATA_WIDTH:0]   r_q_sum;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_i_out;
    logic [DATA_WIDTH-1:0] r_q_out;
    logic                  r_v2;
    logic                  r_busy;

    function automatic logic [DATA_WIDTH-1:0] f_sat(
        input logic [DATA_WIDTH:0] s
    );
        if ($signed(s) > L_MAX) begin
            f_sat = L_MAX[DATA_WIDTH-1:0];
        end else if ($signed(s) < L_MIN) begin
            f_sat = L_MIN[DATA_WIDTH-1:0];
        end else begin
            f_sat = s[DATA_WIDTH-1:0];
        end
    endfunction

    tx_dc_cmp_dc_ramp_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ramp_i (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (s_bus.iq_in_valid),
        .i_en      (s_bus.dc_en),
        .i_target  (s_bus.dc_i_target),
        .i_step    (s_bus.ramp_step),
        .o_applied (w_i_app),
        .o_ramp    (w_i_ramp)
    );

    tx_dc_cmp_dc_ramp_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ramp_q (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (s_bus.iq_in_valid),
        .i_en      (s_bus.dc_en),
        .i_target  (s_bus.dc_q_target),
        .i_step    (s_bus.ramp_step),
        .o_applied (w_q_app),
        .o_ramp    (w_q_ramp)
    );

    // Stage 1 uses the offset before this sample's ramp update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_sum <= '0;
            r_q_sum <= '0;
            r_v1    <= 1'b0;
            r_i_out <= '0;
            r_q_out <= '0;
            r_v2    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_v1   <= s_bus.iq_in_valid;
            r_v2   <= r_v1;
            r_busy <= w_i_ramp | w_q_ramp;
            if (s_bus.iq_in_valid) begin
                r_i_sum <= {s_bus.i_in[DATA_WIDTH-1], s_bus.i_in}
                         + {w_i_app[DATA_WIDTH-1], w_i_app};
                r_q_sum <= {s_bus.q_in[DATA_WIDTH-1], s_bus.q_in}
                         + {w_q_app[DATA_WIDTH-1], w_q_app};
            end
            if (r_v1) begin
                r_i_out <= f_sat(r_i_sum);
                r_q_out <= f_sat(r_q_sum);
            end
        end
    end

    assign s_bus.i_out        = r_i_out;
    assign s_bus.q_out        = r_q_out;
    assign s_bus.iq_out_valid = r_v2;
    assign s_bus.ramp_busy    = r_busy;

endmodule
